// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register command sequencer.
// Holds the shift-register mode codes, the command op codes and the
// sequencer FSM state encoding.
package usr_pkg;

    // Mode codes driven to universal_shift_reg
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Command op codes
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for universal_shift_reg.
// Accepts LOAD / SHR / SHL / NOP commands over a valid/ready handshake and
// drives the shift register's mode, serial_in and parallel_in cycle by cycle,
// pulsing done for one cycle when each command completes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   cmd_valid    command present
//   cmd_ready    sequencer can accept a command (transfer on valid & ready)
//   cmd_op       00 NOP, 01 SHR, 10 SHL, 11 LOAD
//   cmd_data     LOAD value, or serial bit source for shifts (LSB first)
//   cmd_count    number of shift cycles, clamped to WIDTH at acceptance
//   busy         command accepted and not yet finished
//   done         one-cycle completion pulse
//   mode         to shift register: 00 hold, 01 SHR, 10 SHL, 11 load
//   serial_in    to shift register serial input
//   parallel_in  to shift register parallel input
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       mode,
    output logic             serial_in,
    output logic [WIDTH-1:0] parallel_in
);

    // Shift count saturates at the register width
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        if (c > CNT_W'(WIDTH)) begin
            return CNT_W'(WIDTH);
        end
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             serial_q, serial_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    // Captured command payload; only meaningful while a command is in flight
    logic [WIDTH-1:0] sdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_acc;
    logic             accept;

    assign accept  = (state_q == ST_IDLE) && cmd_valid && ready_q;
    assign cnt_acc = sat_count(cmd_count);

    always_comb begin
        state_d  = state_q;
        mode_d   = MODE_HOLD;
        serial_d = 1'b0;
        par_d    = par_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        ready_d  = 1'b0;
        idx_d    = idx_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                idx_d   = '0;
                if (accept) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d = ST_LOAD;
                            mode_d  = MODE_LOAD;
                            par_d   = cmd_data;
                        end
                        OP_SHR, OP_SHL: begin
                            if (cnt_acc == '0) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d  = ST_SHIFT;
                                mode_d   = (cmd_op == OP_SHR) ? MODE_SHR : MODE_SHL;
                                serial_d = cmd_data[0];
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b1;
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                // idx_q is the bit currently on serial_in; last bit ends the shift
                if ((idx_q + CNT_W'(1)) == cnt_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d    = idx_q + CNT_W'(1);
                    mode_d   = mode_q;
                    serial_d = sdata_q[0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_HOLD;
            serial_q <= 1'b0;
            par_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            serial_q <= serial_d;
            par_q    <= par_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            idx_q    <= idx_d;
        end
    end

    // Bit 0 goes out on the accept edge, so the register keeps the remaining
    // bits pre-shifted: sdata_q[0] is always the next bit to send.
    always_ff @(posedge clk) begin
        if (accept) begin
            sdata_q <= cmd_data >> 1;
            cnt_q   <= cnt_acc;
        end else if (state_q == ST_SHIFT) begin
            sdata_q <= sdata_q >> 1;
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mode        = mode_q;
    assign serial_in   = serial_q;
    assign parallel_in = par_q;

endmodule
